cs: RTL and testbench

Streaming 9-sample smoothing filter. Each clock it takes one unsigned 8-bit sample `X` and keeps the 9 most recent samples as a window. It outputs a 10-bit value `Y` that combines the window sum with the window element nearest to, but not above, the mean. It sits in the pixel/sample datapath as a single-clock, one-sample-per-cycle filter with no handshake.

---
 rtl/cs.sv | 64 ++++++
 tb/tb_cs.sv | 101 ++++++++++
 2 files changed

// File: rtl/cs.sv
// 9-sample streaming smoothing filter: Y blends the window sum with the
// window element nearest to, but not above, the window mean.
module cs (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] X,
  output logic [9:0] Y
);

  localparam int unsigned N = 9;

  logic [7:0]  win      [N];
  logic [7:0]  win_next [N];
  logic [11:0] sum;
  logic [7:0]  xavg;
  logic [7:0]  xappr;
  logic [12:0] total;
  logic [9:0]  y_next;

  // The result is computed from the shifted window, so the sample captured at
  // this edge already contributes to Y at the same edge.
  always_comb begin
    win_next[0] = X;
    for (int k = 1; k < N; k++) begin
      win_next[k] = win[k-1];
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the loops so no latch is inferred.
    sum   = '0;
    xappr = '0;
    for (int k = 0; k < N; k++) begin
      sum = sum + 12'(win_next[k]);
    end
    xavg = 8'(sum / 12'd9);
    // Starting from 0 is safe: the window minimum never exceeds the mean.
    for (int k = 0; k < N; k++) begin
      if (win_next[k] <= xavg && win_next[k] > xappr) begin
        xappr = win_next[k];
      end
    end
    total  = 13'(sum) + 13'(xappr) * 13'd9;
    y_next = 10'(total >> 3);
  end

  // NOTE: the window is a handful of flops rather than a RAM, so it is cleared
  // on reset; stale samples must not leak into results after a mid-stream reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        win[k] <= '0;
      end
      Y <= '0;
    end else begin
      // NOTE: non-blocking assignments keep the shift order-independent.
      for (int k = 0; k < N; k++) begin
        win[k] <= win_next[k];
      end
      Y <= y_next;
    end
  end

endmodule

// File: tb/tb_cs.sv
// Directed self-checking bench for the cs smoothing filter.
module tb_cs;

  logic       clk;
  logic       reset;
  logic [7:0] X;
  logic [9:0] Y;

  int checks;
  int fails;

  cs dut (
    .clk   (clk),
    .reset (reset),
    .X     (X),
    .Y     (Y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed Y=%0d expected Y=%0d", tag, obs, exp);
    end
  endtask

  // Drive one sample away from the edge, then sample Y just after the edge.
  task automatic step(input logic rst_v, input logic [7:0] x_v);
    @(negedge clk);
    reset = rst_v;
    X     = x_v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    reset  = 1'b0;
    X      = 8'hFF;

    // Reset held for two edges with X=0xFF.
    step(1'b0, 8'hFF);
    check("reset_hold0", Y, 10'd0);
    step(1'b0, 8'hFF);
    check("reset_hold1", Y, 10'd0);

    // First sample after release: S=9, Xavg=1, Xappr=0.
    step(1'b1, 8'd9);
    check("first_sample", Y, 10'd1);

    // Window {10,9,0x7}: S=19, Xavg=2, Xappr=0.
    step(1'b1, 8'd10);
    check("const_fill1", Y, 10'd2);
    for (int i = 0; i < 8; i++) step(1'b1, 8'd10);
    check("const_full", Y, 10'd22);
    step(1'b1, 8'd10);
    check("const_hold", Y, 10'd22);

    // Ramp 1..9 then 10.
    for (int i = 1; i <= 9; i++) step(1'b1, 8'(i));
    check("ramp_1_9", Y, 10'd11);
    step(1'b1, 8'd10);
    check("ramp_2_10", Y, 10'd13);

    // Outlier: eight zeros then 90, then another zero.
    for (int i = 0; i < 8; i++) step(1'b1, 8'd0);
    step(1'b1, 8'd90);
    check("outlier", Y, 10'd11);
    step(1'b1, 8'd0);
    check("outlier_next", Y, 10'd11);

    // Saturation and drain.
    for (int i = 0; i < 9; i++) step(1'b1, 8'd255);
    check("saturate", Y, 10'd573);
    for (int i = 0; i < 8; i++) step(1'b1, 8'd0);
    // One 255 left: S=255, Xavg=28, Xappr=0.
    check("drain_8", Y, 10'd31);
    step(1'b1, 8'd0);
    check("drain_9", Y, 10'd0);

    // Full window of 200s, then a one-edge reset pulse.
    for (int i = 0; i < 9; i++) step(1'b1, 8'd200);
    check("full_200", Y, 10'd450);
    step(1'b0, 8'd200);
    check("mid_reset", Y, 10'd0);
    step(1'b1, 8'd8);
    check("post_reset1", Y, 10'd1);
    // Window {8,8,0x7}: S=16, Xavg=1, Xappr=0.
    step(1'b1, 8'd8);
    check("post_reset2", Y, 10'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
